bcd_to_binary: RTL and testbench
================================

// Module: bcd_to_binary
// PURPOSE
//  Sequential reverse double-dabble converter: packed BCD -> unsigned binary.
//  Inverse of the seven-seg path's binary-to-BCD block. Used to turn BCD-entered
//  or BCD-stored values (score, high score, settings) back into binary for arithmetic.
//  One conversion at a time, start/data-valid handshake, multi-cycle latency.
// PARAMETERS
//  DECIMAL_DIGITS  3   number of BCD digits on i_BCD (>=1)
//  OUTPUT_WIDTH    10  width of o_Binary = number of shift iterations (>=2, <=255)
// PORTS
//  i_Clock     in   1                  system clock, rising edge
//  i_Reset_n   in   1                  asynchronous, active-low reset
//  i_BCD       in   DECIMAL_DIGITS*4   packed BCD, digit 0 in [3:0]
//  i_Start     in   1                  request; sampled only in IDLE
//  o_Binary    out  OUTPUT_WIDTH       result; held until the next accepted start
//  o_DV        out  1                  one-cycle pulse, o_Binary/flags valid
//  o_Busy      out  1                  high in every state except IDLE
//  o_Err       out  1                  some input digit was >9; valid with o_DV
//  o_Overflow  out  1                  value >= 2**OUTPUT_WIDTH; valid with o_DV
// BEHAVIOUR
//  - Reset (async, i_Reset_n=0): state IDLE, all registers and outputs 0,
//    loop/digit counters 0. Asserting mid-conversion aborts it; no o_DV issued.
//  - Datapath: r_BCD (DECIMAL_DIGITS*4) and r_Binary (OUTPUT_WIDTH).
//  - States: IDLE, SHIFT, CHECK_SHIFT_INDEX, SUB, CHECK_DIGIT_INDEX, DONE.
//  - IDLE: o_DV<=0. If i_Start: r_BCD<=i_BCD, r_Binary<=0, latch o_Err =
//    OR over digits (digit>9), -> SHIFT. Else stay.
//  - SHIFT: {r_BCD,r_Binary} <= {r_BCD,r_Binary} >> 1 (0 into r_BCD MSB);
//    -> CHECK_SHIFT_INDEX.
//  - CHECK_SHIFT_INDEX: if loop count == OUTPUT_WIDTH-1: count<=0, -> DONE;
//    else count+1, -> SUB.
//  - SUB: current digit d = r_BCD[idx*4+:4]; if d>=8, d<=d-3 (4-bit, no borrow);
//    -> CHECK_DIGIT_INDEX. Binary part never corrected.
//  - CHECK_DIGIT_INDEX: if idx==DECIMAL_DIGITS-1: idx<=0, -> SHIFT; else idx+1, -> SUB.
//  - DONE: o_Binary<=r_Binary, o_Overflow <= (r_BCD!=0), o_DV<=1, -> IDLE.
//    No correction after the final shift.
//  - Latency: o_DV is high (OUTPUT_WIDTH-1)*(2*DECIMAL_DIGITS+2)+3 rising edges
//    after the edge that samples i_Start in IDLE (59 for 3 digits / 8 bits,
//    75 for defaults).
//  - o_Binary, o_Err, o_Overflow update only at DONE (o_Err at accept) and
//    hold afterwards; o_DV is exactly one cycle.
//  - i_Start while busy is ignored (no queueing). i_Start held high: next
//    conversion is accepted in the IDLE cycle right after DONE (back-to-back).
//  - i_BCD is sampled only at accept; later changes do not affect the result.
//  - o_Err=1: o_Binary and o_Overflow are don't-care but deterministic.
//  - o_Overflow=1: o_Binary = value mod 2**OUTPUT_WIDTH.
//  - Counter widths: loop count 8 bits; digit index wide enough for
//    DECIMAL_DIGITS-1.
// TESTING
//  1. Defaults, i_BCD=12'h255, 1-cycle start -> o_DV pulse after 75 edges,
//     o_Binary=255, o_Err=0, o_Overflow=0; o_Busy high throughout.
//  2. i_BCD=12'h999 -> 999 (10'h3E7); i_BCD=12'h000 -> 0; i_BCD=12'h001 -> 1;
//     no flags.
//  3. OUTPUT_WIDTH=8, i_BCD=12'h256 -> o_Overflow=1, o_Binary=0; 12'h255 -> 255, no overflow.
//  4. i_BCD=12'h1A3 -> o_DV with o_Err=1; the next start with 12'h123 -> 123, o_Err=0.
//  5. Pulse i_Start again with a different i_BCD mid-conversion -> ignored;
//     the first result is unchanged. i_Start held high -> back-to-back o_DV pulses,
//     76 edges apart.
//  6. Drop i_Reset_n mid-conversion -> outputs 0 immediately, no o_DV.
//     After release, a new start converts correctly.
//  Scoreboard: exhaustive sweep of 0..999 against the integer model, with
//  randomized start gaps.

Source files
------------

// File: rtl/bcd_to_binary.sv
// Sequential reverse double-dabble: packed BCD in, unsigned binary out.
// One conversion at a time; result and flags are presented with a one-cycle o_DV pulse.
module bcd_to_binary #(
  parameter int DECIMAL_DIGITS = 3,
  parameter int OUTPUT_WIDTH   = 10
) (
  input  logic                          i_Clock,
  input  logic                          i_Reset_n,
  input  logic [DECIMAL_DIGITS*4-1:0]   i_BCD,
  input  logic                          i_Start,
  output logic [OUTPUT_WIDTH-1:0]       o_Binary,
  output logic                          o_DV,
  output logic                          o_Busy,
  output logic                          o_Err,
  output logic                          o_Overflow
);

  localparam int BCD_W = DECIMAL_DIGITS * 4;
  localparam int IDX_W = (DECIMAL_DIGITS > 1) ? $clog2(DECIMAL_DIGITS) : 1;
  localparam logic [7:0]       LAST_LOOP = 8'(OUTPUT_WIDTH - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DECIMAL_DIGITS - 1);

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_SHIFT       = 3'd1,
    S_CHECK_SHIFT = 3'd2,
    S_SUB         = 3'd3,
    S_CHECK_DIGIT = 3'd4,
    S_DONE        = 3'd5
  } state_t;

  function automatic logic bcd_invalid(input logic [BCD_W-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int k = 0; k < DECIMAL_DIGITS; k++) begin
      bad = bad | (v[k*4 +: 4] > 4'd9);
    end
    return bad;
  endfunction

  // Undo the "+3" of the forward direction once a digit has absorbed a shifted-in bit.
  function automatic logic [3:0] digit_fix(input logic [3:0] d);
    return (d >= 4'd8) ? (d - 4'd3) : d;
  endfunction

  state_t                  state_r, state_s;
  logic [BCD_W-1:0]        bcd_r, bcd_s;
  logic [OUTPUT_WIDTH-1:0] binary_r, binary_s;
  logic [7:0]              loop_r, loop_s;
  logic [IDX_W-1:0]        idx_r, idx_s;
  logic [OUTPUT_WIDTH-1:0] bin_out_r, bin_out_s;
  logic                    dv_r, dv_s;
  logic                    busy_r, busy_s;
  logic                    err_r, err_s;
  logic                    ovf_r, ovf_s;

  // Next-state, datapath and output computation.
  always_comb begin
    state_s   = state_r;
    bcd_s     = bcd_r;
    binary_s  = binary_r;
    loop_s    = loop_r;
    idx_s     = idx_r;
    bin_out_s = bin_out_r;
    dv_s      = 1'b0;
    err_s     = err_r;
    ovf_s     = ovf_r;
    case (state_r)
      S_IDLE: begin
        if (i_Start) begin
          bcd_s    = i_BCD;
          binary_s = {OUTPUT_WIDTH{1'b0}};
          err_s    = bcd_invalid(i_BCD);
          state_s  = S_SHIFT;
        end else begin
          state_s  = S_IDLE;
        end
      end
      S_SHIFT: begin
        bcd_s    = {1'b0, bcd_r[BCD_W-1:1]};
        binary_s = {bcd_r[0], binary_r[OUTPUT_WIDTH-1:1]};
        state_s  = S_CHECK_SHIFT;
      end
      S_CHECK_SHIFT: begin
        if (loop_r == LAST_LOOP) begin
          loop_s  = 8'd0;
          state_s = S_DONE;
        end else begin
          loop_s  = loop_r + 8'd1;
          state_s = S_SUB;
        end
      end
      S_SUB: begin
        for (int k = 0; k < DECIMAL_DIGITS; k++) begin
          bcd_s[k*4 +: 4] = (IDX_W'(k) == idx_r) ? digit_fix(bcd_r[k*4 +: 4]) : bcd_r[k*4 +: 4];
        end
        state_s = S_CHECK_DIGIT;
      end
      S_CHECK_DIGIT: begin
        if (idx_r == LAST_IDX) begin
          idx_s   = {IDX_W{1'b0}};
          state_s = S_SHIFT;
        end else begin
          idx_s   = idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
          state_s = S_SUB;
        end
      end
      S_DONE: begin
        // Anything left in the BCD field is value >> OUTPUT_WIDTH, i.e. overflow.
        bin_out_s = binary_r;
        ovf_s     = (bcd_r != {BCD_W{1'b0}});
        dv_s      = 1'b1;
        state_s   = S_IDLE;
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
    busy_s = (state_s != S_IDLE);
  end

  // State, datapath and output registers.
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state_r   <= S_IDLE;
      bcd_r     <= {BCD_W{1'b0}};
      binary_r  <= {OUTPUT_WIDTH{1'b0}};
      loop_r    <= 8'd0;
      idx_r     <= {IDX_W{1'b0}};
      bin_out_r <= {OUTPUT_WIDTH{1'b0}};
      dv_r      <= 1'b0;
      busy_r    <= 1'b0;
      err_r     <= 1'b0;
      ovf_r     <= 1'b0;
    end else begin
      state_r   <= state_s;
      bcd_r     <= bcd_s;
      binary_r  <= binary_s;
      loop_r    <= loop_s;
      idx_r     <= idx_s;
      bin_out_r <= bin_out_s;
      dv_r      <= dv_s;
      busy_r    <= busy_s;
      err_r     <= err_s;
      ovf_r     <= ovf_s;
    end
  end

  assign o_Binary   = bin_out_r;
  assign o_DV       = dv_r;
  assign o_Busy     = busy_r;
  assign o_Err      = err_r;
  assign o_Overflow = ovf_r;

endmodule

// File: tb/tb_bcd_to_binary.sv
// Scoreboard bench for bcd_to_binary: a 3-digit/10-bit instance (A) and a 3-digit/8-bit instance (B).
module tb_bcd_to_binary;

  localparam int LAT_A = 75;
  localparam int LAT_B = 59;

  typedef struct {
    logic [9:0] bin;
    logic       err;
    logic       ovf;
    int         acc_cyc;
    int         dv_cyc;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [11:0] bcd_a, bcd_b;
  logic        start_a, start_b;
  logic [9:0]  bin_a;
  logic [7:0]  bin_b;
  logic        dv_a, busy_a, err_a, ovf_a;
  logic        dv_b, busy_b, err_b, ovf_b;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t ea, eb;
  int   cyc = 0;
  int   pass_cnt = 0;
  int   total_cnt = 0;
  int   busy_bad_a = 0;
  int   busy_bad_b = 0;

  bcd_to_binary #(.DECIMAL_DIGITS(3), .OUTPUT_WIDTH(10)) u_dut_a (
    .i_Clock(clk), .i_Reset_n(rst_n), .i_BCD(bcd_a), .i_Start(start_a),
    .o_Binary(bin_a), .o_DV(dv_a), .o_Busy(busy_a), .o_Err(err_a), .o_Overflow(ovf_a)
  );

  bcd_to_binary #(.DECIMAL_DIGITS(3), .OUTPUT_WIDTH(8)) u_dut_b (
    .i_Clock(clk), .i_Reset_n(rst_n), .i_BCD(bcd_b), .i_Start(start_b),
    .o_Binary(bin_b), .o_DV(dv_b), .o_Busy(busy_b), .o_Err(err_b), .o_Overflow(ovf_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    total_cnt++;
    if (act == req) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
  endtask

  function automatic logic [11:0] to_bcd(input int v);
    logic [3:0] h, t, o;
    h = 4'(v / 100);
    t = 4'((v / 10) % 10);
    o = 4'(v % 10);
    return {h, t, o};
  endfunction

  // Wait for the selected DUT to be idle, present one start, and queue the expected response.
  task automatic do_conv(input bit sel, input logic [11:0] v, input int exp_bin,
                         input bit exp_err, input bit exp_ovf, input bit hold);
    int   n;
    exp_t e;
    n = 0;
    @(negedge clk);
    while ((sel ? busy_b : busy_a) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) check(sel ? "b_idle_timeout" : "a_idle_timeout", 1, 0);
    e.bin     = 10'(exp_bin);
    e.err     = exp_err;
    e.ovf     = exp_ovf;
    e.acc_cyc = cyc + 1;
    e.dv_cyc  = cyc + 1 + (sel ? LAT_B : LAT_A);
    if (sel) begin
      bcd_b = v; start_b = 1'b1; q_b.push_back(e);
    end else begin
      bcd_a = v; start_a = 1'b1; q_a.push_back(e);
    end
    @(negedge clk);
    if (!hold) begin
      if (sel) start_b = 1'b0;
      else     start_a = 1'b0;
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((q_a.size() != 0 || q_b.size() != 0) && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("drain_a", q_a.size(), 0);
    check("drain_b", q_b.size(), 0);
  endtask

  // Monitor A: busy throughout each conversion, then latency and result on o_DV.
  always @(negedge clk) begin
    if (rst_n) begin
      if (q_a.size() > 0) begin
        if (cyc >= q_a[0].acc_cyc && cyc < q_a[0].dv_cyc && !busy_a) busy_bad_a++;
      end
      if (dv_a) begin
        if (q_a.size() == 0) begin
          check("a_unexpected_dv", 1, 0);
        end else begin
          ea = q_a.pop_front();
          check("a_latency", cyc, ea.dv_cyc);
          check("a_err", int'(err_a), int'(ea.err));
          if (!ea.err) begin
            check("a_bin", int'(bin_a), int'(ea.bin));
            check("a_ovf", int'(ovf_a), int'(ea.ovf));
          end
          check("a_busy_gap", busy_bad_a, 0);
          busy_bad_a = 0;
        end
      end
    end
  end

  // Monitor B: same checks for the 8-bit instance.
  always @(negedge clk) begin
    if (rst_n) begin
      if (q_b.size() > 0) begin
        if (cyc >= q_b[0].acc_cyc && cyc < q_b[0].dv_cyc && !busy_b) busy_bad_b++;
      end
      if (dv_b) begin
        if (q_b.size() == 0) begin
          check("b_unexpected_dv", 1, 0);
        end else begin
          eb = q_b.pop_front();
          check("b_latency", cyc, eb.dv_cyc);
          check("b_err", int'(err_b), int'(eb.err));
          if (!eb.err) begin
            check("b_bin", int'(bin_b), int'(eb.bin));
            check("b_ovf", int'(ovf_b), int'(eb.ovf));
          end
          check("b_busy_gap", busy_bad_b, 0);
          busy_bad_b = 0;
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; bcd_a = 12'h000; bcd_b = 12'h000;
    repeat (3) @(negedge clk);
    check("rst_a_bin", int'(bin_a), 0);
    check("rst_a_dv", int'(dv_a), 0);
    check("rst_a_busy", int'(busy_a), 0);
    check("rst_a_err", int'(err_a), 0);
    check("rst_a_ovf", int'(ovf_a), 0);
    check("rst_b_bin", int'(bin_b), 0);
    rst_n = 1'b1;

    // Directed conversions, default width.
    do_conv(1'b0, 12'h255, 255, 1'b0, 1'b0, 1'b0);
    do_conv(1'b0, 12'h999, 999, 1'b0, 1'b0, 1'b0);
    do_conv(1'b0, 12'h000, 0,   1'b0, 1'b0, 1'b0);
    do_conv(1'b0, 12'h001, 1,   1'b0, 1'b0, 1'b0);
    do_conv(1'b0, 12'h1A3, 0,   1'b1, 1'b0, 1'b0);
    do_conv(1'b0, 12'h123, 123, 1'b0, 1'b0, 1'b0);

    // 8-bit instance: overflow boundary.
    do_conv(1'b1, 12'h256, 0,   1'b0, 1'b1, 1'b0);
    do_conv(1'b1, 12'h255, 255, 1'b0, 1'b0, 1'b0);
    do_conv(1'b1, 12'h999, 231, 1'b0, 1'b1, 1'b0);

    // Start pulse and input change mid-conversion are ignored.
    do_conv(1'b0, 12'h255, 255, 1'b0, 1'b0, 1'b0);
    repeat (10) @(negedge clk);
    bcd_a = 12'h999; start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    do_conv(1'b0, 12'h300, 300, 1'b0, 1'b0, 1'b0);

    // Held start: back-to-back conversions, 76 edges apart.
    do_conv(1'b0, 12'h777, 777, 1'b0, 1'b0, 1'b1);
    do_conv(1'b0, 12'h042, 42,  1'b0, 1'b0, 1'b0);

    // Reset mid-conversion aborts with no o_DV.
    do_conv(1'b0, 12'h999, 999, 1'b0, 1'b0, 1'b0);
    wait_drain();
    do_conv(1'b0, 12'h500, 500, 1'b0, 1'b0, 1'b0);
    repeat (20) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_a_bin", int'(bin_a), 0);
    check("abort_a_busy", int'(busy_a), 0);
    check("abort_a_dv", int'(dv_a), 0);
    check("abort_b_bin", int'(bin_b), 0);
    check("abort_b_ovf", int'(ovf_b), 0);
    q_a.delete();
    busy_bad_a = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    do_conv(1'b0, 12'h042, 42, 1'b0, 1'b0, 1'b0);
    wait_drain();

    // Sweep 0..999 split across both instances, random start gaps.
    fork
      for (int v = 0; v < 1000; v += 2) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        do_conv(1'b0, to_bcd(v), v, 1'b0, 1'b0, 1'b0);
      end
      for (int w = 1; w < 1000; w += 2) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        do_conv(1'b1, to_bcd(w), w % 256, 1'b0, (w >= 256), 1'b0);
      end
    join
    wait_drain();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
